uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmit controller that sequences one serial frame per accepted byte, timing each bit with an internal bit-period counter (terminal count `CLK_DIV`, same role as the standalone `counter` block's `cnt_max`). It sits between the byte source (CPU/bus side) and the `txd` pin. It owns frame sequencing, bit timing and the ready/valid byte handshake.

## Interface
- `CLK_DIV`, default 32: clocks per serial bit; legal range ≥ 2.
- `DATA_W`, default 8: data bits per frame; legal range 5..8.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `tx_data`  in  DATA_W  byte to send; sampled only on acceptance.
- `tx_valid`  in  1  source has a byte.
- `tx_ready`  out  1  controller can accept; high only in IDLE with `rst_n` high.
- `txd`  out  1  serial line, registered; idle level 1.
- `busy`  out  1  registered; high from START through the last stop cycle.
- `frame_done`  out  1  registered one-cycle pulse in the cycle after the last stop-bit cycle.

## Operation
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- **Acceptance:** occurs on a rising edge where `tx_valid && tx_ready`. That edge does all of the following:
  - latches `tx_data` into a shift register;
  - clears the bit counter;
  - enters START and sets `txd`=0 and `busy`=1.
- **Bit counter:** width `$clog2(CLK_DIV)`. It increments every cycle outside IDLE. It wraps to 0 after reaching `CLK_DIV-1`. The wrap cycle is the bit-end event.
- **START:** on bit-end, go to DATA and drive `txd` = data bit 0.
- **DATA:** LSB first. Bit index runs 0..`DATA_W-1`. At each bit-end, shift to the next bit. After the bit-end of bit `DATA_W-1`, go to PARITY if it is compiled in, else to STOP (`txd`=1).
- **STOP:** lasts `CLK_DIV*STOP_BITS` cycles with `txd`=1. At its final bit-end:
  - go to IDLE;
  - set `busy`=0;
  - pulse `frame_done` high for one cycle.
- **Stale data:** `tx_valid` and `tx_data` are ignored outside IDLE. Changes to `tx_data` mid-frame do not affect the frame in flight.
- **Back-to-back:** `tx_ready` is high in the IDLE cycle that follows STOP. A source holding `tx_valid` high gets the next frame accepted in that cycle. The minimum gap between frames is therefore 1 idle cycle at `txd`=1.
- **Reset:** while `rst_n` is low on an edge, state=IDLE, counters and shift register are cleared, `txd`=1, `busy`=0, `frame_done`=0. While `rst_n` is low, `tx_ready` is 0 (combinationally gated).
- **Reset mid-frame:** the frame is aborted at the next edge and the line returns high. No `frame_done` pulse is produced.

## Timing
- Latency from the acceptance edge to the `txd` falling edge: 0 cycles (the same edge).
- Each bit is held for exactly `CLK_DIV` cycles.
- Frame duration is `CLK_DIV*(1+DATA_W+P+STOP_BITS)` cycles, where P=1 with parity compiled in and 0 without. Default: 32*10 = 320 cycles.
- `frame_done` asserts on the edge that ends the frame, together with `busy` falling. `tx_ready` rises in the same cycle.
- Throughput: one frame per frame duration + 1 cycles.

## Configuration
- `UART_TX_PARITY_EN`:
  - **Defined:** a PARITY state of `CLK_DIV` cycles is inserted between DATA and STOP. `txd` = XOR of the latched data bits (even parity).
  - **Undefined:** no PARITY state, P=0, and DATA goes directly to STOP.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `tx_valid`=1 → `txd`=1, `busy`=0, `tx_ready`=0, `frame_done`=0. After release, `tx_ready`=1.
- **Single frame:** defaults, send 0xA5 → `txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 32 cycles. `busy` high for 320 cycles. One `frame_done` pulse at cycle 320 after acceptance.
- **Back-to-back:** `tx_valid` held high with 0x00 then 0xFF → second start bit begins exactly 321 cycles after the first acceptance, with one idle cycle at `txd`=1.
- **Ignore while busy:** change `tx_data` to 0x3C and pulse `tx_valid` mid-frame → the transmitted frame is unchanged and `tx_ready` stays 0 until IDLE.
- **Reset mid-frame:** assert `rst_n`=0 at cycle 100 of a frame → on the next edge `txd`=1, `busy`=0, no `frame_done`. A new frame accepted after release is sent correctly.
- **Parity and stop bits:** with `UART_TX_PARITY_EN` defined and `STOP_BITS`=2, send 0x07 → parity bit 1, two stop bits, frame lasts 32*12 = 384 cycles.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- UART transmit frame sequencer.
//
// Sends one serial frame per accepted byte:
//   start(0), DATA_W data bits LSB first, optional even parity, STOP_BITS stop(1).
// Each bit is held for CLK_DIV clocks, timed by an internal bit-period counter.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit is inserted between the data and stop bits
//   undefined -> no parity bit; data goes straight to stop
//
// Ports:
//   clk_i         clock, all logic on rising edge
//   rst_n_i       synchronous active-low reset
//   tx_data_i     byte to send, sampled on acceptance only
//   tx_valid_i    source has a byte
//   tx_ready_o    controller can accept (IDLE and not in reset)
//   txd_o         registered serial line, idles high
//   busy_o        registered, high from start bit through last stop cycle
//   frame_done_o  registered one-cycle pulse after the last stop cycle

module uart_tx_ctrl #(
   parameter int CLK_DIV   = 32,
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic              txd_o,
   output logic              busy_o,
   output logic              frame_done_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              stop_q, stop_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              txd_q, txd_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   logic bit_end;
   logic accept;

   assign tx_ready_o   = (state_q == S_IDLE) && rst_n_i;
   assign accept       = tx_valid_i && tx_ready_o;
   // Wrap cycle of the bit-period counter marks the end of the current bit.
   assign bit_end      = (state_q != S_IDLE) && (cnt_q == CW'(CLK_DIV - 1));

   assign txd_o        = txd_q;
   assign busy_o       = busy_q;
   assign frame_done_o = done_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      sh_d    = sh_q;
      txd_d   = txd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif

      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_START;
               sh_d    = tx_data_i;
               cnt_d   = '0;
               bit_d   = '0;
               stop_d  = 1'b0;
               txd_d   = 1'b0;
               busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
               // Parity taken up front since the shift register is consumed.
               par_d   = ^tx_data_i;
`endif
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               txd_d   = sh_q[0];
            end
         end

         S_DATA: begin
            if (bit_end) begin
               if (bit_q == BW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  txd_d   = par_q;
`else
                  state_d = S_STOP;
                  txd_d   = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
                  sh_d  = sh_q >> 1;
                  txd_d = sh_q[1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               txd_d   = 1'b1;
            end
         end
`endif

         S_STOP: begin
            if (bit_end) begin
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  txd_d   = 1'b1;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         sh_q    <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         sh_q    <= sh_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed scenarios plus randomized
// frames, checked cycle by cycle against a frame model built from bit slots.

module tb_uart_tx_ctrl;

   localparam int CD = 32;
   localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
   localparam int P  = 1;
   localparam int SB = 2;
`else
   localparam int P  = 0;
   localparam int SB = 1;
`endif
   localparam int FL = CD * (1 + DW + P + SB);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic          txd;
   logic          busy;
   logic          frame_done;

   int checks = 0;
   int errors = 0;

   uart_tx_ctrl #(.CLK_DIV(CD), .DATA_W(DW), .STOP_BITS(SB)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .tx_data_i    (tx_data),
      .tx_valid_i   (tx_valid),
      .tx_ready_o   (tx_ready),
      .txd_o        (txd),
      .busy_o       (busy),
      .frame_done_o (frame_done)
   );

   always #5 clk = ~clk;

   // Expected line level for a given bit slot of a frame carrying d.
   function automatic logic exp_txd(input logic [DW-1:0] d, input int slot);
      if (slot == 0) return 1'b0;
      if (slot <= DW) return d[slot-1];
      if (P == 1 && slot == DW + 1) return ^d;
      return 1'b1;
   endfunction

   // Present d with valid and step through the acceptance edge.
   task automatic start_frame(input logic [DW-1:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      #1;
      checks++;
      if (tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_before_accept got %b exp 1", tx_ready);
      end
      @(posedge clk);
   endtask

   // Called right after the acceptance edge. Samples FL+1 cycles.
   // hold: keep valid high and present nxt for a back-to-back frame.
   // mutate: poke data/valid mid-frame; frame must be unaffected.
   task automatic check_frame(input logic [DW-1:0] d, input bit hold,
                              input logic [DW-1:0] nxt, input bit mutate);
      logic e;
      for (int k = 0; k <= FL; k++) begin
         @(negedge clk);
         if (k < FL) begin
            e = exp_txd(d, k / CD);
            checks += 4;
            if (txd !== e) begin
               errors++;
               $display("FAIL txd d=%h k=%0d got %b exp %b", d, k, txd, e);
            end
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL busy d=%h k=%0d got %b exp 1", d, k, busy);
            end
            if (frame_done !== 1'b0) begin
               errors++;
               $display("FAIL done_early d=%h k=%0d got %b exp 0", d, k, frame_done);
            end
            if (tx_ready !== 1'b0) begin
               errors++;
               $display("FAIL ready_busy d=%h k=%0d got %b exp 0", d, k, tx_ready);
            end
         end else begin
            checks += 4;
            if (txd !== 1'b1) begin
               errors++;
               $display("FAIL txd_end d=%h got %b exp 1", d, txd);
            end
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL busy_end d=%h got %b exp 0", d, busy);
            end
            if (frame_done !== 1'b1) begin
               errors++;
               $display("FAIL frame_done d=%h got %b exp 1", d, frame_done);
            end
            if (tx_ready !== 1'b1) begin
               errors++;
               $display("FAIL ready_end d=%h got %b exp 1", d, tx_ready);
            end
         end
         if (k == 0) begin
            if (hold) tx_data = nxt;
            else begin
               tx_valid = 1'b0;
               tx_data  = DW'($urandom);
            end
         end
         if (mutate && k == 100) begin
            tx_data  = DW'(8'h3C);
            tx_valid = 1'b1;
         end
         if (mutate && k == 101) tx_valid = 1'b0;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks += 3;
         if (txd !== 1'b1) begin
            errors++;
            $display("FAIL idle_txd i=%0d got %b exp 1", i, txd);
         end
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy i=%0d got %b exp 0", i, busy);
         end
         if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_done i=%0d got %b exp 0", i, frame_done);
         end
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      tx_valid = 1'b1;
      tx_data  = DW'(8'h55);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 4;
      if (txd !== 1'b1) begin
         errors++;
         $display("FAIL rst_txd got %b exp 1", txd);
      end
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy got %b exp 0", busy);
      end
      if (tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_ready got %b exp 0", tx_ready);
      end
      if (frame_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_done got %b exp 0", frame_done);
      end
      tx_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      checks++;
      if (tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_release_ready got %b exp 1", tx_ready);
      end
      idle_cycles(2);
   endtask

   task automatic test_single_frame();
      start_frame(DW'(8'hA5));
      check_frame(DW'(8'hA5), 1'b0, '0, 1'b0);
      idle_cycles(3);
   endtask

   task automatic test_back_to_back();
      start_frame(DW'(8'h00));
      check_frame(DW'(8'h00), 1'b1, DW'(8'hFF), 1'b0);
      // Second acceptance happens on the next edge: 321 cycles after the first.
      check_frame(DW'(8'hFF), 1'b0, '0, 1'b0);
      idle_cycles(2);
   endtask

   task automatic test_ignore_busy();
      start_frame(DW'(8'hC3));
      check_frame(DW'(8'hC3), 1'b0, '0, 1'b1);
      idle_cycles(2);
   endtask

   task automatic test_reset_mid_frame();
      logic [DW-1:0] d;
      logic          e;
      d = DW'(8'h96);
      start_frame(d);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         e = exp_txd(d, k / CD);
         checks++;
         if (txd !== e) begin
            errors++;
            $display("FAIL mid_txd k=%0d got %b exp %b", k, txd, e);
         end
         if (k == 0) tx_valid = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks += 3;
      if (txd !== 1'b1) begin
         errors++;
         $display("FAIL abort_txd got %b exp 1", txd);
      end
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy got %b exp 0", busy);
      end
      if (frame_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_done got %b exp 0", frame_done);
      end
      rst_n = 1'b1;
      idle_cycles(5);
      d = DW'($urandom);
      start_frame(d);
      check_frame(d, 1'b0, '0, 1'b0);
      idle_cycles(1);
   endtask

   task automatic test_parity_stop();
      start_frame(DW'(8'h07));
      check_frame(DW'(8'h07), 1'b0, '0, 1'b0);
      idle_cycles(1);
   endtask

   task automatic test_random();
      logic [DW-1:0] cur;
      logic [DW-1:0] nxt;
      bit            hold;
      cur = DW'($urandom);
      start_frame(cur);
      for (int i = 0; i < 10; i++) begin
         hold = (i < 9) && ($urandom_range(0, 1) == 1);
         nxt  = DW'($urandom);
         check_frame(cur, hold, nxt, 1'b0);
         cur = nxt;
         if (!hold) begin
            idle_cycles($urandom_range(1, 4));
            if (i < 9) start_frame(cur);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_ignore_busy();
      test_reset_mid_frame();
      test_parity_stop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
